// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin owner lock sharing one I2C master between two requesters
// Optional grant watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
    parameter int ReadCountWidth = 8,
    parameter int DataWidth      = 8,
    parameter int TimeoutCycles  = 65535
) (
    input  logic                      Clk_i,
    input  logic                      Reset_i,
    input  logic                      Req0_i,
    output logic                      Grant0_o,
    input  logic                      Req0_ReceiveSend_n_i,
    input  logic [ReadCountWidth-1:0] Req0_ReadCount_i,
    input  logic                      Req0_StartProcess_i,
    input  logic                      Req0_FIFOReadNext_i,
    input  logic                      Req0_FIFOWrite_i,
    input  logic [DataWidth-1:0]      Req0_Data_i,
    output logic                      Req0_Busy_o,
    output logic                      Req0_Error_o,
    input  logic                      Req1_i,
    output logic                      Grant1_o,
    input  logic                      Req1_ReceiveSend_n_i,
    input  logic [ReadCountWidth-1:0] Req1_ReadCount_i,
    input  logic                      Req1_StartProcess_i,
    input  logic                      Req1_FIFOReadNext_i,
    input  logic                      Req1_FIFOWrite_i,
    input  logic [DataWidth-1:0]      Req1_Data_i,
    output logic                      Req1_Busy_o,
    output logic                      Req1_Error_o,
    output logic [DataWidth-1:0]      Req_Data_o,
    output logic                      I2C_ReceiveSend_n_o,
    output logic [ReadCountWidth-1:0] I2C_ReadCount_o,
    output logic                      I2C_StartProcess_o,
    output logic                      I2C_FIFOReadNext_o,
    output logic                      I2C_FIFOWrite_o,
    output logic [DataWidth-1:0]      I2C_Data_o,
    input  logic                      I2C_Busy_i,
    input  logic                      I2C_Error_i,
    input  logic [DataWidth-1:0]      I2C_Data_i,
    output logic                      Timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   last_s, last_nxt;
    logic   timeout_hit;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TimeoutCycles);
    logic [15:0] grant_cnt;

    // Counter is zero on the first granted cycle since every grant is entered from IDLE
    always_ff @(posedge Clk_i) begin
        if (Reset_i || !(state == GRANT0 || state == GRANT1)) begin
            grant_cnt <= 16'd0;
        end else begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == GRANT0 || state == GRANT1) && (grant_cnt == TIMEOUT_LIM);
`else
    assign timeout_hit = 1'b0;
`endif

    assign Timeout_o = timeout_hit;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state  <= IDLE;
            last_s <= 1'b1;
        end else begin
            state  <= state_nxt;
            last_s <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_s;
        case (state)
            IDLE: begin
                if (Req0_i && Req1_i) begin
                    state_nxt = last_s ? GRANT0 : GRANT1;
                end else if (Req0_i) begin
                    state_nxt = GRANT0;
                end else if (Req1_i) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                // A transfer in flight keeps the lock even after the request drops
                if (timeout_hit || (!Req0_i && !I2C_Busy_i)) begin
                    state_nxt = HOLDOFF;
                    last_nxt  = 1'b0;
                end
            end
            GRANT1: begin
                if (timeout_hit || (!Req1_i && !I2C_Busy_i)) begin
                    state_nxt = HOLDOFF;
                    last_nxt  = 1'b1;
                end
            end
            HOLDOFF: begin
                if (!I2C_Busy_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Grant0_o     = (state == GRANT0);
    assign Grant1_o     = (state == GRANT1);
    assign Req0_Busy_o  = Grant0_o ? I2C_Busy_i : 1'b1;
    assign Req1_Busy_o  = Grant1_o ? I2C_Busy_i : 1'b1;
    assign Req0_Error_o = Grant0_o & I2C_Error_i;
    assign Req1_Error_o = Grant1_o & I2C_Error_i;
    assign Req_Data_o   = I2C_Data_i;

    always_comb begin
        I2C_ReceiveSend_n_o = 1'b0;
        I2C_ReadCount_o     = '0;
        I2C_StartProcess_o  = 1'b0;
        I2C_FIFOReadNext_o  = 1'b0;
        I2C_FIFOWrite_o     = 1'b0;
        I2C_Data_o          = '0;
        if (Grant0_o) begin
            I2C_ReceiveSend_n_o = Req0_ReceiveSend_n_i;
            I2C_ReadCount_o     = Req0_ReadCount_i;
            I2C_StartProcess_o  = Req0_StartProcess_i;
            I2C_FIFOReadNext_o  = Req0_FIFOReadNext_i;
            I2C_FIFOWrite_o     = Req0_FIFOWrite_i;
            I2C_Data_o          = Req0_Data_i;
        end else if (Grant1_o) begin
            I2C_ReceiveSend_n_o = Req1_ReceiveSend_n_i;
            I2C_ReadCount_o     = Req1_ReadCount_i;
            I2C_StartProcess_o  = Req1_StartProcess_i;
            I2C_FIFOReadNext_o  = Req1_FIFOReadNext_i;
            I2C_FIFOWrite_o     = Req1_FIFOWrite_i;
            I2C_Data_o          = Req1_Data_i;
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - directed self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

    logic       Clk_i = 1'b0;
    logic       Reset_i;
    logic       Req0_i, Req1_i;
    logic       Grant0_o, Grant1_o;
    logic       Req0_ReceiveSend_n_i, Req1_ReceiveSend_n_i;
    logic [7:0] Req0_ReadCount_i, Req1_ReadCount_i;
    logic       Req0_StartProcess_i, Req1_StartProcess_i;
    logic       Req0_FIFOReadNext_i, Req1_FIFOReadNext_i;
    logic       Req0_FIFOWrite_i, Req1_FIFOWrite_i;
    logic [7:0] Req0_Data_i, Req1_Data_i;
    logic       Req0_Busy_o, Req1_Busy_o, Req0_Error_o, Req1_Error_o;
    logic [7:0] Req_Data_o;
    logic       I2C_ReceiveSend_n_o;
    logic [7:0] I2C_ReadCount_o;
    logic       I2C_StartProcess_o, I2C_FIFOReadNext_o, I2C_FIFOWrite_o;
    logic [7:0] I2C_Data_o;
    logic       I2C_Busy_i, I2C_Error_i;
    logic [7:0] I2C_Data_i;
    logic       Timeout_o;

    int total = 0;
    int bad   = 0;

    always #5 Clk_i = ~Clk_i;

    i2c_master_arbiter #(.ReadCountWidth(8), .DataWidth(8), .TimeoutCycles(10)) dut (
        .Clk_i(Clk_i), .Reset_i(Reset_i),
        .Req0_i(Req0_i), .Grant0_o(Grant0_o),
        .Req0_ReceiveSend_n_i(Req0_ReceiveSend_n_i), .Req0_ReadCount_i(Req0_ReadCount_i),
        .Req0_StartProcess_i(Req0_StartProcess_i), .Req0_FIFOReadNext_i(Req0_FIFOReadNext_i),
        .Req0_FIFOWrite_i(Req0_FIFOWrite_i), .Req0_Data_i(Req0_Data_i),
        .Req0_Busy_o(Req0_Busy_o), .Req0_Error_o(Req0_Error_o),
        .Req1_i(Req1_i), .Grant1_o(Grant1_o),
        .Req1_ReceiveSend_n_i(Req1_ReceiveSend_n_i), .Req1_ReadCount_i(Req1_ReadCount_i),
        .Req1_StartProcess_i(Req1_StartProcess_i), .Req1_FIFOReadNext_i(Req1_FIFOReadNext_i),
        .Req1_FIFOWrite_i(Req1_FIFOWrite_i), .Req1_Data_i(Req1_Data_i),
        .Req1_Busy_o(Req1_Busy_o), .Req1_Error_o(Req1_Error_o),
        .Req_Data_o(Req_Data_o),
        .I2C_ReceiveSend_n_o(I2C_ReceiveSend_n_o), .I2C_ReadCount_o(I2C_ReadCount_o),
        .I2C_StartProcess_o(I2C_StartProcess_o), .I2C_FIFOReadNext_o(I2C_FIFOReadNext_o),
        .I2C_FIFOWrite_o(I2C_FIFOWrite_o), .I2C_Data_o(I2C_Data_o),
        .I2C_Busy_i(I2C_Busy_i), .I2C_Error_i(I2C_Error_i), .I2C_Data_i(I2C_Data_i),
        .Timeout_o(Timeout_o)
    );

    task automatic tick;
        @(posedge Clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        Req0_i = 0; Req1_i = 0;
        Req0_ReceiveSend_n_i = 0; Req1_ReceiveSend_n_i = 0;
        Req0_ReadCount_i = 0; Req1_ReadCount_i = 0;
        Req0_StartProcess_i = 0; Req1_StartProcess_i = 0;
        Req0_FIFOReadNext_i = 0; Req1_FIFOReadNext_i = 0;
        Req0_FIFOWrite_i = 0; Req1_FIFOWrite_i = 0;
        Req0_Data_i = 0; Req1_Data_i = 0;
        I2C_Busy_i = 0; I2C_Error_i = 0; I2C_Data_i = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        Reset_i = 1;
        tick();
        tick();
        Reset_i = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        Reset_i = 1;
        Req0_Data_i = 8'h3c;
        tick();
        #1;
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b00) begin
            bad++; $display("FAIL reset_grant: got %b want 00", {Grant0_o, Grant1_o});
        end
        total++;
        if ({Req0_Busy_o, Req1_Busy_o, Req0_Error_o, Req1_Error_o, Timeout_o} !== 5'b11000) begin
            bad++; $display("FAIL reset_status: got %b want 11000",
                            {Req0_Busy_o, Req1_Busy_o, Req0_Error_o, Req1_Error_o, Timeout_o});
        end
        total++;
        if ({I2C_ReceiveSend_n_o, I2C_ReadCount_o, I2C_StartProcess_o, I2C_FIFOReadNext_o,
             I2C_FIFOWrite_o, I2C_Data_o} !== 20'h0) begin
            bad++; $display("FAIL reset_i2c_outs: got data=%h want all zero", I2C_Data_o);
        end
        Reset_i = 0;
    endtask

    task automatic test_single_grant;
        do_reset();
        tick();
        Req0_i = 1;
        #1;
        total++;
        if (Grant0_o !== 1'b0) begin
            bad++; $display("FAIL grant_latency_early: got %b want 0", Grant0_o);
        end
        tick();
        total++;
        if (Grant0_o !== 1'b1) begin
            bad++; $display("FAIL grant0_single: got %b want 1", Grant0_o);
        end
        Req0_StartProcess_i = 1; Req0_FIFOWrite_i = 1; Req0_ReceiveSend_n_i = 1;
        Req0_ReadCount_i = 8'h03; Req0_Data_i = 8'ha5; I2C_Busy_i = 1;
        #1;
        total++;
        if ({I2C_StartProcess_o, I2C_FIFOWrite_o, I2C_ReceiveSend_n_o, I2C_ReadCount_o, I2C_Data_o}
            !== {3'b111, 8'h03, 8'ha5}) begin
            bad++; $display("FAIL pass_through0: got start=%b wr=%b rs=%b rc=%h d=%h want 1 1 1 03 a5",
                            I2C_StartProcess_o, I2C_FIFOWrite_o, I2C_ReceiveSend_n_o,
                            I2C_ReadCount_o, I2C_Data_o);
        end
        total++;
        if ({Req0_Busy_o, Req1_Busy_o} !== 2'b11) begin
            bad++; $display("FAIL busy_busy: got %b want 11", {Req0_Busy_o, Req1_Busy_o});
        end
        I2C_Busy_i = 0;
        #1;
        total++;
        if ({Req0_Busy_o, Req1_Busy_o} !== 2'b01) begin
            bad++; $display("FAIL busy_idle: got %b want 01", {Req0_Busy_o, Req1_Busy_o});
        end
        Req0_StartProcess_i = 0; Req0_FIFOWrite_i = 0; Req0_i = 0;
        tick();
        total++;
        if ({Grant0_o, Grant1_o, I2C_Data_o, I2C_ReceiveSend_n_o, I2C_ReadCount_o} !== 18'h0) begin
            bad++; $display("FAIL holdoff_outs: got g=%b%b d=%h want 00 00",
                            Grant0_o, Grant1_o, I2C_Data_o);
        end
    endtask

    task automatic test_round_robin;
        do_reset();
        Req0_i = 1; Req1_i = 1;
        tick();
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b10) begin
            bad++; $display("FAIL rr_first: got %b want 10", {Grant0_o, Grant1_o});
        end
        Req0_i = 0;
        tick();
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b00) begin
            bad++; $display("FAIL rr_holdoff: got %b want 00", {Grant0_o, Grant1_o});
        end
        tick();
        tick();
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b01) begin
            bad++; $display("FAIL rr_second: got %b want 01", {Grant0_o, Grant1_o});
        end
        Req1_i = 0;
        tick();
        Req0_i = 1; Req1_i = 1;
        tick();
        tick();
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b10) begin
            bad++; $display("FAIL rr_third: got %b want 10", {Grant0_o, Grant1_o});
        end
    endtask

    task automatic test_busy_hold;
        do_reset();
        Req1_i = 1;
        tick();
        Req0_i = 1;
        tick();
        I2C_Busy_i = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) Req1_i = 0;
            tick();
            total++;
            if ({Grant0_o, Grant1_o, Timeout_o} !== 3'b010) begin
                bad++; $display("FAIL busy_hold[%0d]: got %b want 010", i, {Grant0_o, Grant1_o, Timeout_o});
            end
        end
        I2C_Busy_i = 0;
        tick();
        tick();
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b00) begin
            bad++; $display("FAIL busy_release_gap: got %b want 00", {Grant0_o, Grant1_o});
        end
        tick();
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b10) begin
            bad++; $display("FAIL busy_pending0: got %b want 10", {Grant0_o, Grant1_o});
        end
    endtask

    task automatic test_isolation;
        do_reset();
        Req0_i = 1; Req1_i = 1;
        tick();
        Req0_Data_i = 8'h11;
        Req1_StartProcess_i = 1; Req1_FIFOWrite_i = 1; Req1_FIFOReadNext_i = 1;
        Req1_Data_i = 8'hee; Req1_ReadCount_i = 8'h77;
        I2C_Error_i = 1; I2C_Data_i = 8'h5a;
        #1;
        total++;
        if ({I2C_StartProcess_o, I2C_FIFOWrite_o, I2C_FIFOReadNext_o, I2C_ReadCount_o, I2C_Data_o}
            !== {3'b000, 8'h00, 8'h11}) begin
            bad++; $display("FAIL iso_strobes: got s=%b w=%b r=%b rc=%h d=%h want 0 0 0 00 11",
                            I2C_StartProcess_o, I2C_FIFOWrite_o, I2C_FIFOReadNext_o,
                            I2C_ReadCount_o, I2C_Data_o);
        end
        total++;
        if ({Req0_Error_o, Req1_Error_o, Req1_Busy_o} !== 3'b101) begin
            bad++; $display("FAIL iso_error: got %b want 101", {Req0_Error_o, Req1_Error_o, Req1_Busy_o});
        end
        total++;
        if (Req_Data_o !== 8'h5a) begin
            bad++; $display("FAIL rx_broadcast: got %h want 5a", Req_Data_o);
        end
        Req0_StartProcess_i = 1;
        #1;
        total++;
        if ({I2C_StartProcess_o, I2C_FIFOWrite_o} !== 2'b10) begin
            bad++; $display("FAIL iso_own_start: got %b want 10", {I2C_StartProcess_o, I2C_FIFOWrite_o});
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        Req1_i = 1;
        tick();
        I2C_Busy_i = 1; Req1_StartProcess_i = 1; Req1_Data_i = 8'h42; Req1_ReceiveSend_n_i = 1;
        Reset_i = 1;
        tick();
        total++;
        if ({Grant0_o, Grant1_o, I2C_StartProcess_o, I2C_ReceiveSend_n_o, I2C_Data_o} !== 12'h0) begin
            bad++; $display("FAIL reset_mid: got g=%b%b s=%b d=%h want 00 0 00",
                            Grant0_o, Grant1_o, I2C_StartProcess_o, I2C_Data_o);
        end
        Reset_i = 0; I2C_Busy_i = 0; Req0_i = 1;
        tick();
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b10) begin
            bad++; $display("FAIL reset_mid_tie: got %b want 10", {Grant0_o, Grant1_o});
        end
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        Req0_i = 1; Req1_i = 1; I2C_Busy_i = 1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            total++;
            if ({Grant0_o, Timeout_o} !== 2'b10) begin
                bad++; $display("FAIL to_wait[%0d]: got %b want 10", i, {Grant0_o, Timeout_o});
            end
            tick();
        end
        total++;
        if ({Grant0_o, Timeout_o} !== 2'b11) begin
            bad++; $display("FAIL to_pulse: got %b want 11", {Grant0_o, Timeout_o});
        end
        tick();
        total++;
        if ({Grant0_o, Grant1_o, Timeout_o} !== 3'b000) begin
            bad++; $display("FAIL to_revoke: got %b want 000", {Grant0_o, Grant1_o, Timeout_o});
        end
        tick();
        I2C_Busy_i = 0;
        tick();
        tick();
        total++;
        if ({Grant0_o, Grant1_o} !== 2'b01) begin
            bad++; $display("FAIL to_pending1: got %b want 01", {Grant0_o, Grant1_o});
        end
    endtask
`endif

    initial begin
        clear_inputs();
        Reset_i = 1;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_busy_hold();
        test_isolation();
        test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
